// File: rtl/uart_rx_to_axis_if.sv
// AXI-Stream beat bundle for the UART receiver output.
// tuser {frame_err, parity_err} exists only with UART_RX_ERR_TUSER_EN.
interface uart_rx_to_axis_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
`ifdef UART_RX_ERR_TUSER_EN
  logic [1:0] tuser;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    output tready
  );
`else
  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
`endif
endinterface

// File: rtl/uart_rx_to_axis.sv
// UART receiver: RX frames to AXI-Stream beats via a one-beat output register.
// UART_RX_ERR_TUSER_EN: deliver errored words with tuser flags instead of dropping.
module uart_rx_to_axis #(
  parameter int CLK_FREQ      = 100,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              RX,
  uart_rx_to_axis_if.master axis
);

  localparam int BIT_CYCLES = (CLK_FREQ * 1_000_000) / BIT_RATE;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT = 3'(BIT_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [CW-1:0] r_cnt;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par_err;
  logic          r_frm_err;
  logic          r_armed;
  logic          r_dlv;
  logic [7:0]    r_tdata;
  logic          r_tvalid;

  logic w_half;
  logic w_mid;
  logic w_last_bit;
  logic w_stop_smp;
  logic w_last_stop;
  logic w_cnt_clr;
  logic w_par_exp;
  logic w_ok;
  logic w_take;

  assign w_half     = (r_cnt == HALF_M1);
  assign w_mid      = (r_cnt == BIT_M1);
  assign w_last_bit = (r_bit == LAST_BIT);
  assign w_par_exp  = (PARITY_BIT == 1) ? ~^r_shift : ^r_shift;

  assign w_stop_smp = w_mid &&
                      (r_state == S_STOP1 || r_state == S_STOP2);
  assign w_last_stop = (r_state == S_STOP2) ||
                       (r_state == S_STOP1 && STOP_BITS_NUM != 2);

  assign w_cnt_clr = (w_state_n != r_state) || w_mid ||
                     (r_state == S_IDLE);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:
        if (r_armed && !r_rx_s) w_state_n = S_START;
      S_START:
        if (w_half) w_state_n = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (w_mid && w_last_bit)
          w_state_n = (PARITY_BIT != 0) ? S_PARITY : S_STOP1;
      S_PARITY:
        if (w_mid) w_state_n = S_STOP1;
      S_STOP1:
        if (w_mid)
          w_state_n = (STOP_BITS_NUM == 2) ? S_STOP2 : S_IDLE;
      S_STOP2:
        if (w_mid) w_state_n = S_IDLE;
      default:
        w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_shift   <= '0;
      r_bit     <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_armed   <= 1'b1;
      r_dlv     <= 1'b0;
    end else begin
      r_dlv <= w_stop_smp && w_last_stop;
      if (r_state == S_START) begin
        r_shift   <= '0;
        r_bit     <= '0;
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
      end
      if (r_state == S_DATA && w_mid) begin
        r_shift[r_bit] <= r_rx_s;
        r_bit          <= r_bit + 1'b1;
      end
      if (r_state == S_PARITY && w_mid)
        r_par_err <= (r_rx_s != w_par_exp);
      if (w_stop_smp)
        r_frm_err <= r_frm_err | ~r_rx_s;
      // a broken frame may leave the line low; rearm only once it idles
      if (w_stop_smp && w_last_stop && (r_frm_err || !r_rx_s))
        r_armed <= 1'b0;
      else if (r_state == S_IDLE && r_rx_s)
        r_armed <= 1'b1;
    end
  end

`ifdef UART_RX_ERR_TUSER_EN
  assign w_ok = 1'b1;
`else
  assign w_ok = ~(r_par_err | r_frm_err);
`endif

  // a word arriving while the held beat is stalled is dropped
  assign w_take = r_dlv && w_ok && (!r_tvalid || axis.tready);

`ifdef UART_RX_ERR_TUSER_EN
  logic [1:0] r_tuser;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_tuser <= '0;
    else if (w_take) r_tuser <= {r_frm_err, r_par_err};
  end

  assign axis.tuser = r_tuser;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else if (w_take) begin
      r_tvalid <= 1'b1;
      r_tdata  <= r_shift;
    end else if (axis.tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign axis.tdata  = r_tdata;
  assign axis.tvalid = r_tvalid;

endmodule
